// File: rtl/riscv_pkg.sv
// Shared constants for the multicycle RISC-V control unit: opcodes, FSM state
// encoding, ALU operation codes, immediate formats and writeback selects.
// Optional feature macro: CONTROLLER_MC_RV32M_EN adds the S_MULDIV state.
package riscv_pkg;

    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned STATE_W  = 5;

    // Base RV32I major opcodes
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'h01;

    typedef enum logic [STATE_W-1:0] {
        S_RESET   = 5'd0,
        S_FETCH   = 5'd1,
        S_DECODE  = 5'd2,
        S_EXEC_R  = 5'd3,
        S_EXEC_I  = 5'd4,
        S_MEM_ADR = 5'd5,
        S_MEM_RD  = 5'd6,
        S_MEM_WB  = 5'd7,
        S_MEM_WR  = 5'd8,
        S_BRANCH  = 5'd9,
        S_JAL     = 5'd10,
        S_JALR    = 5'd11,
        S_LUI     = 5'd12,
        S_AUIPC   = 5'd13,
        S_ALU_WB  = 5'd14,
        S_HALT    = 5'd15,
        S_TRAP    = 5'd16
`ifdef CONTROLLER_MC_RV32M_EN
        ,
        S_MULDIV  = 5'd17
`endif
    } state_e;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_XOR  = 4'h3;
    localparam logic [3:0] ALU_OR   = 4'h4;
    localparam logic [3:0] ALU_AND  = 4'h5;
    localparam logic [3:0] ALU_SLL  = 4'h6;
    localparam logic [3:0] ALU_SRL  = 4'h7;
    localparam logic [3:0] ALU_SRA  = 4'h8;
    localparam logic [3:0] ALU_SLT  = 4'h9;
    localparam logic [3:0] ALU_SLTU = 4'hA;

    // Immediate formats
    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b011;
    localparam logic [2:0] IMM_B    = 3'b100;
    localparam logic [2:0] IMM_J    = 3'b101;
    localparam logic [2:0] IMM_U    = 3'b110;

    // Writeback / PC source select
    localparam logic [1:0] RES_ALU    = 2'b00;
    localparam logic [1:0] RES_ALUOUT = 2'b01;
    localparam logic [1:0] RES_MEM    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    // ALU operand selects
    localparam logic [1:0] SRCA_OLDPC = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

endpackage

// File: rtl/controller_mc_alu_decoder.sv
// ALU operation decode from {funct3, funct7[5]}.
// Ports: funct3, funct7 (instruction fields), is_imm (OP-IMM form), alu_ctrl (ALU op).
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       is_imm,
    output logic [3:0] alu_ctrl
);

    // Only funct7[5] carries ALU meaning here
    logic unused_funct7;
    assign unused_funct7 = ^{funct7[6], funct7[4:0]};

    // funct7[5] picks sub only for register form; it picks sra for both forms
    always_comb begin
        alu_ctrl = ALU_ADD;
        case (funct3)
            3'b000:  alu_ctrl = (funct7[5] && !is_imm) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_ctrl = ALU_SLL;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b011:  alu_ctrl = ALU_SLTU;
            3'b100:  alu_ctrl = ALU_XOR;
            3'b101:  alu_ctrl = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_ctrl = ALU_OR;
            default: alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/controller_mc.sv
// Multicycle RV32I control FSM with memory wait timeout.
// Ports: clk/rst (async active-high); opcode/funct3/funct7 from IR; zero_flag/alu_lt
// compare flags; mem_ready handshake; memory, register-file, PC, mux and ALU controls;
// halted/illegal status; state (debug).
// Optional macro CONTROLLER_MC_RV32M_EN adds the MULDIV state and md_start/md_op/md_done.
module controller_mc
    import riscv_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter logic [6:0]  HALT_OPCODE = 7'b1111111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero_flag,
    input  logic       alu_lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic [2:0] mem_size,
    output logic       adr_src,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_sel,
    output logic [2:0] imm_sel,
    output logic [1:0] alu_src_a_sel,
    output logic [1:0] alu_src_b_sel,
    output logic [3:0] alu_ctrl,
    output logic       halted,
    output logic       illegal,
    output logic [4:0] state
`ifdef CONTROLLER_MC_RV32M_EN
    ,
    output logic       md_start,
    output logic [2:0] md_op,
    input  logic       md_done
`endif
);

    localparam int unsigned CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam bit          TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic             phase_q, phase_d;   // second cycle of JAL/JALR, or MULDIV past start

    logic       mem_state;
    logic       wait_expired;
    logic       br_cond, br_valid, br_taken;
    logic [3:0] dec_alu_ctrl;

    alu_decoder u_alu_decoder (
        .funct3   (funct3),
        .funct7   (funct7),
        .is_imm   (state_q == S_EXEC_I),
        .alu_ctrl (dec_alu_ctrl)
    );

    assign state     = state_q;
    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    // Last permitted wait cycle without mem_ready; a ready in this cycle still wins
    assign wait_expired = TIMEOUT_EN && mem_state && !mem_ready && (wait_q == WAIT_LAST);

    // funct3[2] selects signed/unsigned less-than vs equality, funct3[0] inverts
    assign br_cond  = funct3[2] ? alu_lt : zero_flag;
    assign br_valid = (funct3[2:1] != 2'b01);
    assign br_taken = br_valid && (br_cond ^ funct3[0]);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RESET;
            wait_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            phase_q <= phase_d;
        end
    end

    // Next-state, wait counter and phase
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        phase_d = 1'b0;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    if (state_q == S_FETCH)       state_d = S_DECODE;
                    else if (state_q == S_MEM_RD) state_d = S_MEM_WB;
                    else                          state_d = S_FETCH;
                end else if (wait_expired) begin
                    state_d = S_TRAP;
                end else begin
                    wait_d = TIMEOUT_EN ? wait_q + CNT_W'(1) : '0;
                end
            end
            S_DECODE: begin
                if (opcode == HALT_OPCODE) begin
                    state_d = S_HALT;
                end else begin
                    case (opcode)
                        OP_OP: begin
                            if (funct7 == FUNCT7_MULDIV) begin
`ifdef CONTROLLER_MC_RV32M_EN
                                state_d = S_MULDIV;
`else
                                state_d = S_TRAP;
`endif
                            end else begin
                                state_d = S_EXEC_R;
                            end
                        end
                        OP_OP_IMM:         state_d = S_EXEC_I;
                        OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
                        OP_BRANCH:         state_d = S_BRANCH;
                        OP_JAL:            state_d = S_JAL;
                        OP_JALR:           state_d = S_JALR;
                        OP_LUI:            state_d = S_LUI;
                        OP_AUIPC:          state_d = S_AUIPC;
                        default:           state_d = S_TRAP;
                    endcase
                end
            end
            S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
            S_MEM_ADR: begin
                if (opcode == OP_LOAD) state_d = S_MEM_RD;
                else                   state_d = S_MEM_WR;
            end
            S_BRANCH: begin
                if (br_valid) state_d = S_FETCH;
                else          state_d = S_TRAP;
            end
            S_JAL, S_JALR: begin
                if (phase_q) state_d = S_FETCH;
                else         phase_d = 1'b1;
            end
            S_LUI, S_AUIPC, S_ALU_WB, S_MEM_WB: state_d = S_FETCH;
`ifdef CONTROLLER_MC_RV32M_EN
            S_MULDIV: begin
                if (md_done) state_d = S_FETCH;
                else         phase_d = 1'b1;
            end
`endif
            S_HALT:  state_d = S_HALT;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    // Output decode
    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        mem_size      = MEM_SIZE_WORD;
        adr_src       = 1'b0;
        pc_write      = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_sel    = RES_ALU;
        imm_sel       = IMM_NONE;
        alu_src_a_sel = SRCA_OLDPC;
        alu_src_b_sel = SRCB_RS2;
        alu_ctrl      = ALU_ADD;
        halted        = 1'b0;
        illegal       = 1'b0;
`ifdef CONTROLLER_MC_RV32M_EN
        md_start      = 1'b0;
        md_op         = 3'b000;
`endif
        case (state_q)
            S_FETCH: begin
                mem_req       = 1'b1;
                alu_src_a_sel = SRCA_PC;
                alu_src_b_sel = SRCB_FOUR;
                ir_write      = mem_ready;
                pc_write      = mem_ready;
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut
                alu_src_a_sel = SRCA_OLDPC;
                alu_src_b_sel = SRCB_IMM;
                imm_sel       = IMM_B;
            end
            S_EXEC_R: begin
                alu_src_a_sel = SRCA_RS1;
                alu_src_b_sel = SRCB_RS2;
                alu_ctrl      = dec_alu_ctrl;
            end
            S_EXEC_I: begin
                alu_src_a_sel = SRCA_RS1;
                alu_src_b_sel = SRCB_IMM;
                imm_sel       = IMM_I;
                alu_ctrl      = dec_alu_ctrl;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                result_sel = RES_ALUOUT;
            end
            S_MEM_ADR: begin
                alu_src_a_sel = SRCA_RS1;
                alu_src_b_sel = SRCB_IMM;
                imm_sel       = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_RD, S_MEM_WR: begin
                mem_req   = 1'b1;
                adr_src   = 1'b1;
                mem_size  = funct3;
                mem_write = (state_q == S_MEM_WR);
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                result_sel = RES_MEM;
            end
            S_BRANCH: begin
                alu_src_a_sel = SRCA_RS1;
                alu_src_b_sel = SRCB_RS2;
                alu_ctrl      = !funct3[2] ? ALU_SUB : (funct3[1] ? ALU_SLTU : ALU_SLT);
                if (br_taken) begin
                    pc_write   = 1'b1;
                    result_sel = RES_ALUOUT;
                end
            end
            S_JAL, S_JALR: begin
                // PC is redirected first so a JALR with rd == rs1 still sees the old rs1
                if (!phase_q) begin
                    pc_write      = 1'b1;
                    alu_src_b_sel = SRCB_IMM;
                    if (state_q == S_JAL) begin
                        alu_src_a_sel = SRCA_OLDPC;
                        imm_sel       = IMM_J;
                    end else begin
                        alu_src_a_sel = SRCA_RS1;
                        imm_sel       = IMM_I;
                    end
                end else begin
                    reg_write     = 1'b1;
                    alu_src_a_sel = SRCA_OLDPC;
                    alu_src_b_sel = SRCB_FOUR;
                end
            end
            S_LUI: begin
                imm_sel    = IMM_U;
                reg_write  = 1'b1;
                result_sel = RES_IMM;
            end
            S_AUIPC: begin
                alu_src_a_sel = SRCA_OLDPC;
                alu_src_b_sel = SRCB_IMM;
                imm_sel       = IMM_U;
                reg_write     = 1'b1;
            end
`ifdef CONTROLLER_MC_RV32M_EN
            S_MULDIV: begin
                md_op    = funct3;
                md_start = !phase_q;
                if (md_done) begin
                    reg_write  = 1'b1;
                    result_sel = RES_ALUOUT;
                end
            end
`endif
            S_HALT:  halted  = 1'b1;
            S_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_controller_mc.sv
// Self-checking bench for controller_mc: each instruction is expanded into an
// expected per-cycle trace from the instruction-class rules, then replayed.
module tb_controller_mc;
    import riscv_pkg::*;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       zero_flag, alu_lt, mem_ready;
    logic       mem_req, mem_write, adr_src, pc_write, ir_write, reg_write, halted, illegal;
    logic [2:0] mem_size, imm_sel;
    logic [1:0] result_sel, alu_src_a_sel, alu_src_b_sel;
    logic [3:0] alu_ctrl;
    logic [4:0] state;
`ifdef CONTROLLER_MC_RV32M_EN
    logic       md_start, md_done;
    logic [2:0] md_op;
`endif

    controller_mc #(.MEM_TIMEOUT(TO), .HALT_OPCODE(7'b1111111)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .zero_flag(zero_flag), .alu_lt(alu_lt), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .mem_size(mem_size), .adr_src(adr_src),
        .pc_write(pc_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_sel(result_sel), .imm_sel(imm_sel),
        .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel),
        .alu_ctrl(alu_ctrl), .halted(halted), .illegal(illegal), .state(state)
`ifdef CONTROLLER_MC_RV32M_EN
        , .md_start(md_start), .md_op(md_op), .md_done(md_done)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] st;
        logic       mem_req, mem_write;
        logic [2:0] mem_size;
        logic       adr_src, pc_write, ir_write, reg_write;
        logic [1:0] res;
        logic [2:0] imm;
        logic [1:0] a, b;
        logic [3:0] alu;
        logic       halted, illegal, md_start;
        logic [2:0] md_op;
    } obs_t;

    typedef struct {
        obs_t  o;
        logic  rdy;
        logic  done;
        string tag;
    } cyc_t;

    cyc_t trace[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [6:0] ops [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111,
                             7'b0001011};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (state got %0d exp %0d)",
                     tag, got, exp, got[32:28], exp[32:28]);
        end
    endtask

    function automatic obs_t get_obs();
        obs_t o;
        o.st = state; o.mem_req = mem_req; o.mem_write = mem_write; o.mem_size = mem_size;
        o.adr_src = adr_src; o.pc_write = pc_write; o.ir_write = ir_write;
        o.reg_write = reg_write; o.res = result_sel; o.imm = imm_sel;
        o.a = alu_src_a_sel; o.b = alu_src_b_sel; o.alu = alu_ctrl;
        o.halted = halted; o.illegal = illegal;
`ifdef CONTROLLER_MC_RV32M_EN
        o.md_start = md_start; o.md_op = md_op;
`else
        o.md_start = 1'b0; o.md_op = 3'b000;
`endif
        return o;
    endfunction

    // Idle values: everything low except add and word size
    function automatic obs_t dflt(input state_e st);
        obs_t o = '0;
        o.st = st; o.alu = 4'h1; o.mem_size = 3'b010;
        return o;
    endfunction

    function automatic void add(input obs_t o, input logic rdy, input logic done, input string tag);
        cyc_t c;
        c.o = o; c.rdy = rdy; c.done = done; c.tag = tag;
        trace.push_back(c);
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    // Memory wait: ready after 'delay' idle cycles; no ready within TO cycles means timeout
    function automatic bit mem_phase(input obs_t w, input obs_t d, input int delay, input string tag);
        for (int i = 0; i < int'(TO); i++) begin
            if (i == delay) begin
                add(d, 1'b1, rb(), tag);
                return 1'b1;
            end
            add(w, 1'b0, rb(), tag);
        end
        return 1'b0;
    endfunction

    function automatic void absorb(input state_e st, input int n);
        obs_t o = dflt(st);
        if (st == S_TRAP) o.illegal = 1'b1;
        else              o.halted  = 1'b1;
        for (int i = 0; i < n; i++) add(o, rb(), rb(), (st == S_TRAP) ? "trap" : "halt");
    endfunction

    function automatic logic [3:0] exp_alu(input logic [2:0] f3, input logic [6:0] f7, input bit imm);
        logic [3:0] tbl [8] = '{4'h1, 4'h6, 4'h9, 4'hA, 4'h3, 4'h7, 4'h4, 4'h5};
        if (f3 == 3'd0 && f7[5] && !imm) return 4'h2;
        if (f3 == 3'd5 && f7[5])         return 4'h8;
        return tbl[f3];
    endfunction

    function automatic obs_t fetch_obs();
        obs_t o = dflt(S_FETCH);
        o.mem_req = 1'b1; o.a = 2'b01; o.b = 2'b10;
        return o;
    endfunction

    // Expected trace of one instruction, starting in the RESET cycle
    function automatic void build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                  input logic zf, input logic lt, input int fd, input int md,
                                  input int mdd, input int tail);
        obs_t o, w;
        bit   taken;
        trace.delete();
        add(dflt(S_RESET), rb(), rb(), "reset");
        w = fetch_obs();
        o = w; o.ir_write = 1'b1; o.pc_write = 1'b1;
        if (!mem_phase(w, o, fd, "fetch")) begin absorb(S_TRAP, tail); return; end
        o = dflt(S_DECODE); o.b = 2'b01; o.imm = 3'b100;
        add(o, rb(), rb(), "decode");
        case (op)
            7'b0110011, 7'b0010011: begin
                if (op == 7'b0110011 && f7 == 7'h01) begin
`ifdef CONTROLLER_MC_RV32M_EN
                    for (int i = 0; ; i++) begin
                        o = dflt(S_MULDIV); o.md_op = f3; o.md_start = (i == 0);
                        if (i == mdd) begin
                            o.reg_write = 1'b1; o.res = 2'b01;
                            add(o, rb(), 1'b1, "muldiv");
                            break;
                        end
                        add(o, rb(), 1'b0, "muldiv");
                    end
`else
                    absorb(S_TRAP, tail);
                    return;
`endif
                end else begin
                    o = dflt((op == 7'b0010011) ? S_EXEC_I : S_EXEC_R);
                    o.a = 2'b10;
                    if (op == 7'b0010011) begin o.b = 2'b01; o.imm = 3'b001; end
                    o.alu = exp_alu(f3, f7, op == 7'b0010011);
                    add(o, rb(), rb(), "exec");
                    o = dflt(S_ALU_WB); o.reg_write = 1'b1; o.res = 2'b01;
                    add(o, rb(), rb(), "alu_wb");
                end
            end
            7'b0000011, 7'b0100011: begin
                o = dflt(S_MEM_ADR); o.a = 2'b10; o.b = 2'b01;
                o.imm = (op == 7'b0100011) ? 3'b011 : 3'b001;
                add(o, rb(), rb(), "mem_adr");
                w = dflt((op == 7'b0100011) ? S_MEM_WR : S_MEM_RD);
                w.mem_req = 1'b1; w.adr_src = 1'b1; w.mem_size = f3;
                w.mem_write = (op == 7'b0100011);
                if (!mem_phase(w, w, md, "mem")) begin absorb(S_TRAP, tail); return; end
                if (op == 7'b0000011) begin
                    o = dflt(S_MEM_WB); o.reg_write = 1'b1; o.res = 2'b10;
                    add(o, rb(), rb(), "mem_wb");
                end
            end
            7'b1100011: begin
                o = dflt(S_BRANCH); o.a = 2'b10;
                case (f3)
                    3'd0: begin taken = zf;  o.alu = 4'h2; end
                    3'd1: begin taken = !zf; o.alu = 4'h2; end
                    3'd4: begin taken = lt;  o.alu = 4'h9; end
                    3'd5: begin taken = !lt; o.alu = 4'h9; end
                    3'd6: begin taken = lt;  o.alu = 4'hA; end
                    3'd7: begin taken = !lt; o.alu = 4'hA; end
                    default: begin taken = 1'b0; o.alu = 4'h2; end
                endcase
                if (taken) begin o.pc_write = 1'b1; o.res = 2'b01; end
                add(o, rb(), rb(), "branch");
                if (f3 == 3'd2 || f3 == 3'd3) begin absorb(S_TRAP, tail); return; end
            end
            7'b1101111, 7'b1100111: begin
                o = dflt((op == 7'b1101111) ? S_JAL : S_JALR);
                o.pc_write = 1'b1; o.b = 2'b01;
                if (op == 7'b1101111) o.imm = 3'b101;
                else begin o.imm = 3'b001; o.a = 2'b10; end
                add(o, rb(), rb(), "jump_pc");
                o = dflt((op == 7'b1101111) ? S_JAL : S_JALR);
                o.reg_write = 1'b1; o.b = 2'b10;
                add(o, rb(), rb(), "jump_link");
            end
            7'b0110111: begin
                o = dflt(S_LUI); o.imm = 3'b110; o.reg_write = 1'b1; o.res = 2'b11;
                add(o, rb(), rb(), "lui");
            end
            7'b0010111: begin
                o = dflt(S_AUIPC); o.b = 2'b01; o.imm = 3'b110; o.reg_write = 1'b1;
                add(o, rb(), rb(), "auipc");
            end
            7'b1111111: begin absorb(S_HALT, tail); return; end
            default:    begin absorb(S_TRAP, tail); return; end
        endcase
        add(fetch_obs(), 1'b0, rb(), "next_fetch");
    endfunction

    // Reset (asynchronously, mid-cycle), then replay the expected trace
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic zf, input logic lt, input int fd, input int md,
                       input int mdd, input int tail);
        opcode = op; funct3 = f3; funct7 = f7; zero_flag = zf; alu_lt = lt;
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("async_reset", 64'(get_obs()), 64'(dflt(S_RESET)));
        @(posedge clk); #1;
        rst = 1'b0;
        build(op, f3, f7, zf, lt, fd, md, mdd, tail);
        foreach (trace[i]) begin
            mem_ready = trace[i].rdy;
`ifdef CONTROLLER_MC_RV32M_EN
            md_done = trace[i].done;
`endif
            @(negedge clk);
            check($sformatf("%s[%0d] op=%b f3=%0d", trace[i].tag, i, op, f3),
                  64'(get_obs()), 64'(trace[i].o));
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [6:0] f7;
        int         fd;
        rst = 1'b1; opcode = '0; funct3 = '0; funct7 = '0;
        zero_flag = 1'b0; alu_lt = 1'b0; mem_ready = 1'b0;
`ifdef CONTROLLER_MC_RV32M_EN
        md_done = 1'b0;
`endif
        @(posedge clk); #1;

        run(7'b0010011, 3'd0, 7'h00, 0, 0, 0, 0, 0, 3);   // addi x1,x0,5
        run(7'b0000011, 3'd2, 7'h00, 0, 0, 0, 3, 0, 3);   // lw, ready after 3
        run(7'b1100011, 3'd0, 7'h00, 1, 0, 0, 0, 0, 3);   // beq taken
        run(7'b1100011, 3'd0, 7'h00, 0, 0, 0, 0, 0, 3);   // beq not taken
        run(7'b1100011, 3'd1, 7'h00, 1, 0, 0, 0, 0, 3);   // bne not taken
        run(7'b1100011, 3'd1, 7'h00, 0, 0, 1, 0, 0, 3);   // bne taken
        run(7'b0010011, 3'd0, 7'h00, 0, 0, 9, 0, 0, 5);   // fetch timeout
        run(7'b0010011, 3'd0, 7'h00, 0, 0, 3, 0, 0, 3);   // ready on last allowed cycle
        run(7'b1111111, 3'd0, 7'h00, 0, 0, 0, 0, 0, 20);  // halt
        run(7'b0001011, 3'd0, 7'h00, 0, 0, 0, 0, 0, 5);   // unknown opcode
        run(7'b0110011, 3'd0, 7'h01, 0, 0, 0, 0, 5, 5);   // mul
        run(7'b0110011, 3'd0, 7'h20, 0, 0, 0, 0, 0, 3);   // sub
        run(7'b0110011, 3'd5, 7'h20, 0, 0, 0, 0, 0, 3);   // sra
        run(7'b0010011, 3'd0, 7'h20, 0, 0, 0, 0, 0, 3);   // addi, funct7[5] ignored
        run(7'b0010011, 3'd5, 7'h20, 0, 0, 0, 0, 0, 3);   // srai
        run(7'b0000011, 3'd0, 7'h00, 0, 0, 0, 9, 0, 4);   // lb, data timeout
        run(7'b0100011, 3'd1, 7'h00, 0, 0, 2, 3, 0, 3);   // sh
        run(7'b1100011, 3'd2, 7'h00, 0, 0, 0, 0, 0, 4);   // invalid branch funct3
        run(7'b1101111, 3'd0, 7'h00, 0, 0, 0, 0, 0, 3);   // jal
        run(7'b1100111, 3'd0, 7'h00, 0, 0, 0, 0, 0, 3);   // jalr
        run(7'b0110111, 3'd0, 7'h00, 0, 0, 0, 0, 0, 3);   // lui
        run(7'b0010111, 3'd0, 7'h00, 0, 0, 0, 0, 0, 3);   // auipc

        for (int n = 0; n < 200; n++) begin
            case ($urandom_range(0, 3))
                0:       f7 = 7'h00;
                1:       f7 = 7'h20;
                2:       f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            fd = ($urandom_range(0, 9) > 7) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            run(ops[$urandom_range(0, 10)], 3'($urandom), f7, rb(), rb(), fd,
                int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 3);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/controller_mc.md
CONTROLLER_MC -- requirements
Module: controller_mc

Interface
REQ-001 The module SHALL have parameter MEM_TIMEOUT (default 16): cycles a memory request may wait for mem_ready; 0 disables the timeout.
REQ-002 The module SHALL have parameter HALT_OPCODE (default 7'b1111111): the opcode that stops the core.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Ports SHALL be, in this order:
- clk  in 1  clock
- rst  in 1  async active-high reset
- opcode  in 7, funct3  in 3, funct7  in 7  fields from the instruction register
- zero_flag  in 1, alu_lt  in 1  ALU compare flags
- mem_ready  in 1  memory completes the current request
- mem_req  out 1, mem_write  out 1, mem_size  out 3 (funct3 during data access, 3'b010 otherwise), adr_src  out 1 (0=PC, 1=ALU result register)
- pc_write  out 1, ir_write  out 1, reg_write  out 1
- result_sel  out 2 (00 ALU, 01 ALUOut, 10 mem data, 11 imm)
- imm_sel  out 3 (001 I, 011 S, 100 B, 101 J, 110 U)
- alu_src_a_sel  out 2 (00 oldPC, 01 PC, 10 rs1), alu_src_b_sel  out 2 (00 rs2, 01 imm, 10 const 4)
- alu_ctrl  out 4 (1 add, 2 sub, 3 xor, 4 or, 5 and, 6 sll, 7 srl, 8 sra, 9 slt, A sltu)
- halted  out 1, illegal  out 1, state  out 5 (debug)

Function
REQ-005 States SHALL be: RESET, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, JALR, LUI, AUIPC, ALU_WB, HALT, TRAP.
REQ-006 All outputs SHALL default to 0 each cycle except alu_ctrl=1 and mem_size=3'b010; each state overrides only what it needs.
REQ-007 RESET SHALL go to FETCH after exactly one cycle, with no writes.
REQ-008 FETCH SHALL assert mem_req with adr_src=0 and hold until mem_ready; in the mem_ready cycle it SHALL assert ir_write and pc_write (PC+4: a=01, b=10, add) and go to DECODE.
REQ-009 DECODE SHALL compute oldPC+B-imm into ALUOut (a=00, b=01, imm_sel=100) and dispatch on opcode:
- R -> EXEC_R; OP-IMM -> EXEC_I; LOAD/STORE -> MEM_ADR; BRANCH -> BRANCH
- JAL -> JAL; JALR -> JALR; LUI -> LUI; AUIPC -> AUIPC
- HALT_OPCODE -> HALT; anything else -> TRAP
REQ-010 EXEC_R and EXEC_I SHALL decode alu_ctrl from {funct3,funct7[5]}, where funct7[5] selects sub/sra; funct7[5] is ignored for OP-IMM except on shifts. Both SHALL then go to ALU_WB.
REQ-011 ALU_WB SHALL assert reg_write with result_sel=01 and go to FETCH.
REQ-012 MEM_ADR SHALL compute rs1+imm (I for loads, S for stores) and go to MEM_RD or MEM_WR.
REQ-013 MEM_RD and MEM_WR SHALL assert mem_req with adr_src=1 and mem_size=funct3 until mem_ready; MEM_WR also drives mem_write. MEM_RD SHALL then go to MEM_WB; MEM_WR SHALL go to FETCH.
REQ-014 MEM_WB SHALL assert reg_write with result_sel=10 and go to FETCH.
REQ-015 BRANCH SHALL compare rs1 against rs2:
- BEQ/BNE use sub and zero_flag; BLT/BGE use slt and alu_lt; BLTU/BGEU use sltu and alu_lt.
- On a taken branch it SHALL assert pc_write with result_sel=01.
- funct3 of 2 or 3 SHALL go to TRAP; otherwise the next state is FETCH.
REQ-016 JAL SHALL write oldPC+4 to rd and load PC with oldPC+J-imm, over two cycles; JALR SHALL do the same with (rs1+I-imm)&~1. Both return to FETCH.
REQ-017 LUI SHALL write the U-immediate (result_sel=11); AUIPC SHALL write oldPC+U-immediate. Each takes one cycle, then goes to FETCH.
REQ-018 HALT SHALL be absorbing with halted=1; TRAP SHALL be absorbing with illegal=1. Only rst leaves either state.
REQ-019 A wait counter SHALL clear on entry to any mem_req state. If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT without mem_ready, the FSM SHALL go to TRAP with no writes. If mem_ready arrives in the same cycle the counter reaches MEM_TIMEOUT, mem_ready wins.
REQ-020 mem_ready SHALL be ignored in all states that do not assert mem_req.

Reset
REQ-021 rst SHALL force state=RESET and clear the wait counter asynchronously; all outputs SHALL take their REQ-006 defaults during reset, including when reset is asserted mid-access or mid-wait.

Configuration
REQ-022 Macro CONTROLLER_MC_RV32M_EN:
- When defined: add state MULDIV, ports md_start out 1, md_op out 3 (=funct3), md_done in 1. R-type with funct7=7'h01 goes to MULDIV, which pulses md_start in its first cycle, waits for md_done, then writes rd (result_sel=01) and goes to FETCH.
- When undefined: funct7=7'h01 R-type SHALL go to TRAP, and the md_* ports SHALL not exist.

Structure
REQ-023 Opcode, state encoding, alu_ctrl, imm_sel and result_sel constants SHALL live in the shared package riscv_pkg.
REQ-024 ALU-control decode SHALL be the sub-module alu_decoder (inputs funct3, funct7, is_imm; output alu_ctrl); the FSM and wait counter stay in controller_mc.

Verification
REQ-025 addi x1,x0,5 with mem_ready tied 1 -> FETCH, DECODE, EXEC_I, ALU_WB; reg_write=1 in cycle 4 with alu_ctrl=1.
REQ-026 lw with mem_ready delayed 3 cycles in MEM_RD -> mem_req held 4 cycles with mem_size=010; a single reg_write with result_sel=10.
REQ-027 beq with zero_flag=1 versus zero_flag=0 -> pc_write=1 in BRANCH versus pc_write=0; bne inverts both.
REQ-028 MEM_TIMEOUT=4 with mem_ready held 0 in FETCH -> TRAP after 4 wait cycles, illegal=1, no ir_write; rst returns to RESET.
REQ-029 opcode 7'b1111111 -> halted=1 and state stays HALT for 20 cycles; opcode 7'b0001011 -> TRAP.
REQ-030 With CONTROLLER_MC_RV32M_EN defined, mul with md_done after 5 cycles -> md_start pulses once, then one reg_write; without the macro the same instruction -> TRAP.
